// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and sizing helpers for the serial adder controller
package serial_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width: max(1, $clog2(width)), with width clamped to the legal range.
  function automatic int cnt_w(input int width);
    int w;
    w = (width > MAX_WIDTH) ? MAX_WIDTH : width;
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_slice.sv
// rtl/serial_add_ctrl_bit_slice.sv - serial_bit_slice: one-bit full-adder slice with carry flip-flop
module serial_bit_slice
  import serial_pkg::*;
(
  input  logic CP,
  input  logic CR,
  input  logic x1,
  input  logic x2,
  input  logic load_carry,
  input  logic init_carry,
  input  logic en,
  output logic s,
  output logic carry
);

  logic carry_d;
  logic carry_q;

  always_comb begin
    carry_d = carry_q;
    if (load_carry) begin
      carry_d = init_carry;
    end else if (en) begin
      carry_d = maj3(x1, x2, carry_q);
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign s     = x1 ^ x2 ^ carry_q;
  assign carry = carry_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first serial adder controller; SERIAL_SUB_EN adds a subtract mode (sub port)
module serial_add_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic shift_en;
  logic s_bit;
  logic carry;
  logic init_carry;
  logic b_inv;

  assign accept   = start & (state_q == IDLE);
  assign shift_en = (state_q == SHIFT);

`ifdef SERIAL_SUB_EN
  // a - b computed as a + ~b + 1; the +1 comes from the preset carry.
  assign init_carry = sub;
  assign b_inv      = sub;
`else
  assign init_carry = 1'b0;
  assign b_inv      = 1'b0;
`endif

  serial_bit_slice u_slice (
    .CP         (CP),
    .CR         (CR),
    .x1         (ra_q[0]),
    .x2         (rb_q[0]),
    .load_carry (accept),
    .init_carry (init_carry),
    .en         (shift_en),
    .s          (s_bit),
    .carry      (carry)
  );

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b_inv ? ~b : b;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d            = ra_q >> 1;
        rb_d            = rb_q >> 1;
        acc_d           = acc_q >> 1;
        acc_d[WIDTH-1]  = s_bit;
        cnt_d           = cnt_q + CW'(1);
        // Result registers load on the last bit so they are valid while done is high.
        if (cnt_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = maj3(ra_q[0], rb_q[0], carry);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl (WIDTH=8 and WIDTH=1 instances)
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  logic         CP = 1'b0;
  logic         CR = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub_r = 1'b0;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         sub1 = 1'b0;
  logic         ready1, busy1, done1, cout1;
  logic [0:0]   sum1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  serial_add_ctrl #(.WIDTH(W)) u_dut (
    .CP(CP), .CR(CR), .start(start), .a(a), .b(b),
`ifdef SERIAL_SUB_EN
    .sub(sub_r),
`endif
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .CP(CP), .CR(CR), .start(start1), .a(a1), .b(b1),
`ifdef SERIAL_SUB_EN
    .sub(sub1),
`endif
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge CP) begin : monitor
    exp_t e;
    if (CR && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("done_without_request", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input logic push, input logic [W-1:0] es, input logic ec,
                       output int acc_cyc);
    int n;
    n = 0;
    @(negedge CP);
    while (!ready && n < 50) begin
      @(negedge CP);
      n++;
    end
    check("ready_before_start", ready, 1);
    a = ta;
    b = tb_v;
    sub_r = ts;
    start = 1'b1;
    @(posedge CP);
    #1;
    start = 1'b0;
    acc_cyc = cyc;
    if (push) sb.push_back('{es, ec, acc_cyc + W});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CP);
      #1;
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int acc, n0, bad, bn;
    CR = 1'b0;
    repeat (2) @(posedge CP);
    #1;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge CP);
    CR = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h96, 1'b0, acc);
    bn = 0;
    repeat (10) begin
      @(negedge CP);
      if (busy) bn++;
    end
    check("busy_cycles", bn, 8);
    wait_drain("op1_drain");

    do_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, acc);
    bad = 0;
    repeat (W) begin
      @(negedge CP);
      if (sum !== 8'h96) bad++;
    end
    check("sum_held_while_busy", bad, 0);
    wait_drain("op2_drain");

    n0 = done_cnt;
    do_op(8'h0F, 8'h0F, 1'b0, 1'b1, 8'h1E, 1'b0, acc);
    repeat (2) @(posedge CP);
    #1;
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(posedge CP);
    #1;
    start = 1'b0;
    wait_drain("op3_drain");
    repeat (12) @(negedge CP);
    check("single_done_pulse", done_cnt - n0, 1);

    n0 = done_cnt;
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 1'b0, acc);
    repeat (4) @(posedge CP);
    #3;
    CR = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    repeat (2) @(negedge CP);
    CR = 1'b1;
    repeat (12) @(negedge CP);
    check("no_done_after_abort", done_cnt - n0, 0);
    do_op(8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, acc);
    wait_drain("op4_drain");

    n0 = done_cnt;
    bn = 0;
    @(negedge CP);
    while (!ready && bn < 50) begin
      @(negedge CP);
      bn++;
    end
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    @(posedge CP);
    #1;
    acc = cyc;
    for (int k = 0; k < 3; k++) sb.push_back('{8'h00, 1'b1, acc + 10 * k + W});
    repeat (21) @(posedge CP);
    #1;
    start = 1'b0;
    wait_drain("held_drain");
    repeat (12) @(negedge CP);
    check("held_done_count", done_cnt - n0, 3);

`ifdef SERIAL_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, acc);
    wait_drain("sub_drain");
    sub_r = 1'b0;
`endif

    @(negedge CP);
    a1 = 1'b1;
    b1 = 1'b1;
    start1 = 1'b1;
    @(posedge CP);
    #1;
    start1 = 1'b0;
    @(negedge CP);
    check("w1_busy", busy1, 1);
    check("w1_done_early", done1, 0);
    @(negedge CP);
    check("w1_done", done1, 1);
    check("w1_sum", sum1, 0);
    check("w1_cout", cout1, 1);
    @(negedge CP);
    check("w1_done_one_cycle", done1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
